// File: rtl/multdiv_pending_unit_pkg.sv
// Shared definitions for the multi-cycle multiply/divide pending-writeback unit.
// Holds the default widths and the FSM state encodings used by the top level.
// The state encodings are plain 2-bit constants so that existing decode logic
// elsewhere in the pipeline can compare against them directly.
package multdiv_pending_unit_pkg;

  localparam int MD_DATA_WIDTH  = 32;
  localparam int MD_CNT_WIDTH   = 5;
  localparam int MD_INSTR_WIDTH = 32;

  typedef logic [1:0] md_state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MULT = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/multdiv_pending_unit_div_restore_step.sv
// div_restore_step: one combinational restoring-division iteration on
// unsigned magnitudes.
// Ports:
//   rem       in   DATA_WIDTH  partial remainder (always < divisor)
//   quo       in   DATA_WIDTH  dividend bits still to shift in / quotient so far
//   divisor   in   DATA_WIDTH  divisor magnitude (non-zero)
//   rem_next  out  DATA_WIDTH  partial remainder after this iteration
//   quo_next  out  DATA_WIDTH  quotient register after this iteration
module div_restore_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem,
  input  logic [DATA_WIDTH-1:0] quo,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] rem_next,
  output logic [DATA_WIDTH-1:0] quo_next
);

  // One extra bit: the shifted remainder can reach 2*divisor-1.
  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] trial;

  assign shifted = {rem, quo[DATA_WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor};

  // trial MSB set means the subtraction borrowed: restore the shifted value.
  assign rem_next = trial[DATA_WIDTH] ? shifted[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];
  assign quo_next = {quo[DATA_WIDTH-2:0], ~trial[DATA_WIDTH]};

endmodule

// File: rtl/multdiv_pending_unit.sv
// multdiv_pending_unit: multi-cycle signed multiply/divide engine and producer
// side of the writeback multdiv path. An issue from execute is accepted in IDLE
// or DONE; the issuing instruction is latched as the pending-writeback
// instruction, the unit iterates DATA_WIDTH times on operand magnitudes and
// then pulses multdiv_resultRDY for one cycle with the signed result.
// Optional feature macro: MULTDIV_OVF_EN -- when defined, multdiv_exception is
// also raised on signed multiply overflow and on 0x80000000 / -1.
// Ports:
//   clock                   in   1   master clock
//   reset                   in   1   synchronous active-high reset
//   start_mult              in   1   issue signed multiply (wins over start_div)
//   start_div               in   1   issue signed divide
//   operand_A               in   W   multiplicand / dividend
//   operand_B               in   W   multiplier / divisor
//   x_instruction_input     in   32  issuing instruction, latched on accept
//   multdiv_busy            out  1   high in MULT, DIV, DONE
//   multdiv_resultRDY       out  1   one-cycle result-valid pulse (DONE)
//   multdiv_output          out  W   result, valid with resultRDY
//   pw_instructions_output  out  32  latched pending-writeback instruction
//   multdiv_exception       out  1   valid with resultRDY
module multdiv_pending_unit
  import multdiv_pending_unit_pkg::*;
#(
  parameter int DATA_WIDTH = MD_DATA_WIDTH,
  parameter int CNT_WIDTH  = MD_CNT_WIDTH
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start_mult,
  input  logic                      start_div,
  input  logic [DATA_WIDTH-1:0]     operand_A,
  input  logic [DATA_WIDTH-1:0]     operand_B,
  input  logic [MD_INSTR_WIDTH-1:0] x_instruction_input,
  output logic                      multdiv_busy,
  output logic                      multdiv_resultRDY,
  output logic [DATA_WIDTH-1:0]     multdiv_output,
  output logic [MD_INSTR_WIDTH-1:0] pw_instructions_output,
  output logic                      multdiv_exception
);

  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(DATA_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  // Shared two's-complement fix-up: operand magnitudes on accept and the
  // final signed result. Negating the most negative value wraps onto itself,
  // which is also its correct unsigned magnitude.
  function automatic logic [DATA_WIDTH-1:0] negate_if(
    input logic [DATA_WIDTH-1:0] v,
    input logic                  neg
  );
    negate_if = neg ? (~v + DATA_WIDTH'(1)) : v;
  endfunction

  md_state_t                 state_reg;
  logic [CNT_WIDTH-1:0]      cnt_reg;
  // Multiply: {partial product high, multiplier shifting out}.
  // Divide:   {partial remainder, dividend shifting out / quotient in}.
  logic [2*W-1:0]            acc_reg;
  logic [W-1:0]              mag_op_reg;   // multiplicand or divisor magnitude
  logic                      neg_reg;      // result sign = signA ^ signB
  logic                      dz_reg;       // divide by zero pending
  logic                      fin_reg;      // all iterations done, fix-up next
  logic [W-1:0]              result_reg;
  logic                      exc_reg;
  logic [MD_INSTR_WIDTH-1:0] pw_reg;

  logic                      start_any;
  logic [W-1:0]              mag_a;
  logic [W-1:0]              mag_b;
  logic [W:0]                mult_sum;
  logic [2*W-1:0]            mult_acc_next;
  logic [W-1:0]              div_rem_next;
  logic [W-1:0]              div_quo_next;

  assign start_any = start_mult | start_div;
  assign mag_a     = negate_if(operand_A, operand_A[W-1]);
  assign mag_b     = negate_if(operand_B, operand_B[W-1]);

  // Radix-2 shift-add step: add the multiplicand into the high half when the
  // current multiplier LSB is set, then shift the whole accumulator right.
  always_comb begin
    mult_sum      = {1'b0, acc_reg[2*W-1:W]} + (acc_reg[0] ? {1'b0, mag_op_reg} : '0);
    mult_acc_next = {mult_sum, acc_reg[W-1:1]};
  end

  div_restore_step #(
    .DATA_WIDTH (W)
  ) u_div_step (
    .rem      (acc_reg[2*W-1:W]),
    .quo      (acc_reg[W-1:0]),
    .divisor  (mag_op_reg),
    .rem_next (div_rem_next),
    .quo_next (div_quo_next)
  );

`ifdef MULTDIV_OVF_EN
  logic ovf_div_reg;
  logic mult_ovf;
  // Product magnitude fits a signed W-bit result when it is at most
  // 2^(W-1)-1 (positive) or 2^(W-1) (negative).
  assign mult_ovf = neg_reg
                  ? ((|acc_reg[2*W-1:W]) | (acc_reg[W-1] & (|acc_reg[W-2:0])))
                  : (|acc_reg[2*W-1:W-1]);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      mag_op_reg <= '0;
      neg_reg    <= 1'b0;
      dz_reg     <= 1'b0;
      fin_reg    <= 1'b0;
      result_reg <= '0;
      exc_reg    <= 1'b0;
      pw_reg     <= '0;
`ifdef MULTDIV_OVF_EN
      ovf_div_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start_any) begin
            pw_reg  <= x_instruction_input;
            cnt_reg <= '0;
            fin_reg <= 1'b0;
            neg_reg <= operand_A[W-1] ^ operand_B[W-1];
            if (start_mult) begin
              state_reg  <= ST_MULT;
              acc_reg    <= {{W{1'b0}}, mag_b};
              mag_op_reg <= mag_a;
              dz_reg     <= 1'b0;
            end else begin
              state_reg  <= ST_DIV;
              acc_reg    <= {{W{1'b0}}, mag_a};
              mag_op_reg <= mag_b;
              dz_reg     <= (operand_B == '0);
            end
`ifdef MULTDIV_OVF_EN
            ovf_div_reg <= ~start_mult
                         & (operand_A == {1'b1, {(W-1){1'b0}}})
                         & (&operand_B);
`endif
          end else begin
            state_reg <= ST_IDLE;
          end
        end

        ST_MULT: begin
          if (fin_reg) begin
            state_reg  <= ST_DONE;
            result_reg <= negate_if(acc_reg[W-1:0], neg_reg);
`ifdef MULTDIV_OVF_EN
            exc_reg    <= mult_ovf;
`else
            exc_reg    <= 1'b0;
`endif
          end else begin
            acc_reg <= mult_acc_next;
            cnt_reg <= cnt_reg + CNT_ONE;
            fin_reg <= (cnt_reg == LAST_ITER);
          end
        end

        ST_DIV: begin
          if (dz_reg) begin
            // Divide by zero short-circuits straight to a zero result.
            state_reg  <= ST_DONE;
            result_reg <= '0;
            exc_reg    <= 1'b1;
          end else if (fin_reg) begin
            state_reg  <= ST_DONE;
            result_reg <= negate_if(acc_reg[W-1:0], neg_reg);
`ifdef MULTDIV_OVF_EN
            exc_reg    <= ovf_div_reg;
`else
            exc_reg    <= 1'b0;
`endif
          end else begin
            acc_reg <= {div_rem_next, div_quo_next};
            cnt_reg <= cnt_reg + CNT_ONE;
            fin_reg <= (cnt_reg == LAST_ITER);
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign multdiv_busy           = (state_reg != ST_IDLE);
  assign multdiv_resultRDY      = (state_reg == ST_DONE);
  assign multdiv_output         = result_reg;
  assign multdiv_exception      = exc_reg;
  assign pw_instructions_output = pw_reg;

endmodule
